// File: rtl/impl_chk_pkg.sv
// rtl/impl_chk_pkg.sv - shared helpers for the bounded-implication checker
package impl_chk_pkg;

    localparam int SAT_W = 64;

    // Channel-index width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Add b to a, clamping the result at max instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input logic [SAT_W-1:0] max
    );
        logic [SAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max}) ? max : sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/impl_chk_channel.sv
// rtl/impl_chk_channel.sv - one channel: attempt age vector, discharge and fail detection
module impl_chk_channel #(
    parameter int  MIN_DLY = 0,
    parameter int  MAX_DLY = 0,
    localparam int DC_W    = $clog2(MAX_DLY + 2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_con,
    output logic            o_fail_det,
    output logic            o_fail,
    output logic [DC_W-1:0] o_disc_cnt
);

    logic [MAX_DLY:0] w_alive;
    logic [MAX_DLY:0] w_disc;
    logic             r_fail;

    generate
        if (MAX_DLY > 0) begin : g_pend
            // r_pend[a] holds the undischarged attempt started a cycles ago.
            logic [MAX_DLY:1] r_pend;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pend <= '0;
                end else begin
                    r_pend <= w_alive[MAX_DLY-1:0] & ~w_disc[MAX_DLY-1:0];
                end
            end

            assign w_alive = {r_pend, i_start};
        end else begin : g_nopend
            assign w_alive = i_start;
        end
    endgenerate

    always_comb begin
        w_disc     = '0;
        o_disc_cnt = '0;
        for (int a = 0; a <= MAX_DLY; a++) begin
            if (a >= MIN_DLY) begin
                w_disc[a] = w_alive[a] & i_con;
            end
            o_disc_cnt = o_disc_cnt + DC_W'(w_disc[a]);
        end
    end

    assign o_fail_det = w_alive[MAX_DLY] & ~w_disc[MAX_DLY];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail <= 1'b0;
        end else begin
            r_fail <= o_fail_det;
        end
    end

    assign o_fail = r_fail;

endmodule

// File: rtl/impl_chk.sv
// rtl/impl_chk.sv - bounded implication checker top; IMPL_CHK_TIMESTAMP_EN enables first-fail timestamp capture
module impl_chk
    import impl_chk_pkg::*;
#(
    parameter int  NUM_CH  = 1,
    parameter int  MIN_DLY = 0,
    parameter int  MAX_DLY = 0,
    parameter int  CNT_W   = 16,
    parameter int  TS_W    = 32,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic [NUM_CH-1:0] antecedent,
    input  logic [NUM_CH-1:0] consequent,
    output logic [NUM_CH-1:0] fail,
    output logic [NUM_CH-1:0] err_sticky,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              first_fail_vld,
    output logic [CH_W-1:0]   first_fail_ch,
    output logic [TS_W-1:0]   first_fail_ts
);

    localparam int DC_W = $clog2(MAX_DLY + 2);
    localparam int PI_W = $clog2(NUM_CH * (MAX_DLY + 1) + 1);
    localparam int FI_W = $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    generate
        if (NUM_CH < 1) begin : g_err_ch
            $error("impl_chk: NUM_CH must be >= 1");
        end
        if (MIN_DLY < 0) begin : g_err_min
            $error("impl_chk: MIN_DLY must be >= 0");
        end
        if (MIN_DLY > MAX_DLY) begin : g_err_win
            $error("impl_chk: MIN_DLY must not exceed MAX_DLY");
        end
    endgenerate

    logic [NUM_CH-1:0] w_fail_det;
    logic [NUM_CH-1:0] w_fail;
    logic [DC_W-1:0]   w_disc_cnt [NUM_CH];
    logic [PI_W-1:0]   w_pass_inc;
    logic [FI_W-1:0]   w_fail_inc;

    logic [NUM_CH-1:0] r_err;
    logic [CNT_W-1:0]  r_pass_cnt;
    logic [CNT_W-1:0]  r_fail_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            impl_chk_channel #(
                .MIN_DLY (MIN_DLY),
                .MAX_DLY (MAX_DLY)
            ) u_channel (
                .clk        (clk),
                .rst        (rst),
                .i_start    (antecedent[gi] & enable),
                .i_con      (consequent[gi]),
                .o_fail_det (w_fail_det[gi]),
                .o_fail     (w_fail[gi]),
                .o_disc_cnt (w_disc_cnt[gi])
            );
        end
    endgenerate

    always_comb begin
        w_pass_inc = '0;
        w_fail_inc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pass_inc = w_pass_inc + PI_W'(w_disc_cnt[i]);
            w_fail_inc = w_fail_inc + FI_W'(w_fail_det[i]);
        end
    end

    // Sticky bits and counters update from the detection cycle so they move with fail.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err      <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else if (clear) begin
            r_err      <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_err      <= r_err | w_fail_det;
            r_pass_cnt <= CNT_W'(sat_add(SAT_W'(r_pass_cnt), SAT_W'(w_pass_inc), SAT_W'(CNT_MAX)));
            r_fail_cnt <= CNT_W'(sat_add(SAT_W'(r_fail_cnt), SAT_W'(w_fail_inc), SAT_W'(CNT_MAX)));
        end
    end

    assign fail       = w_fail;
    assign err_sticky = r_err;
    assign pass_cnt   = r_pass_cnt;
    assign fail_cnt   = r_fail_cnt;

`ifdef IMPL_CHK_TIMESTAMP_EN
    typedef struct packed {
        logic            vld;
        logic [CH_W-1:0] ch;
        logic [TS_W-1:0] ts;
    } ff_rec_t;

    logic [TS_W-1:0] r_ts;
    ff_rec_t         r_ff;
    logic [CH_W-1:0] w_low_ch;

    always_comb begin
        w_low_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_fail_det[i]) begin
                w_low_ch = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= '0;
            r_ff <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            if (clear) begin
                r_ff <= '0;
            end else if (!r_ff.vld && (|w_fail_det)) begin
                r_ff.vld <= 1'b1;
                r_ff.ch  <= w_low_ch;
                r_ff.ts  <= r_ts;
            end
        end
    end

    assign first_fail_vld = r_ff.vld;
    assign first_fail_ch  = r_ff.ch;
    assign first_fail_ts  = r_ff.ts;
`else
    assign first_fail_vld = 1'b0;
    assign first_fail_ch  = '0;
    assign first_fail_ts  = '0;
`endif

endmodule

// File: tb/tb_impl_chk.sv
// tb/tb_impl_chk.sv - directed self-checking bench for impl_chk across several configurations
module tb_impl_chk;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic enable = 1'b1;
    logic clear  = 1'b0;

    logic a0 = 1'b0, c0 = 1'b0;
    logic a1 = 1'b0, c1 = 1'b0;
    logic a2 = 1'b0, c2 = 1'b0;
    logic a4 = 1'b0, c4 = 1'b0;
    logic [3:0] a3 = 4'b0, c3 = 4'b0;

    logic        f0, e0, v0, ch0;
    logic [15:0] pc0, fc0;
    logic [31:0] ts0;
    logic        f1, e1, v1, ch1;
    logic [15:0] pc1, fc1;
    logic [31:0] ts1;
    logic        f2, e2, v2, ch2;
    logic [15:0] pc2, fc2;
    logic [31:0] ts2;
    logic [3:0]  f3, e3;
    logic        v3;
    logic [1:0]  ch3;
    logic [15:0] pc3, fc3;
    logic [31:0] ts3;
    logic        f4, e4, v4, ch4;
    logic [1:0]  pc4, fc4;
    logic [31:0] ts4;

    int checks   = 0;
    int failures = 0;
    int tb_cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    impl_chk #(.NUM_CH(1), .MIN_DLY(0), .MAX_DLY(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .antecedent(a0), .consequent(c0), .fail(f0), .err_sticky(e0),
        .pass_cnt(pc0), .fail_cnt(fc0), .first_fail_vld(v0),
        .first_fail_ch(ch0), .first_fail_ts(ts0));

    impl_chk #(.NUM_CH(1), .MIN_DLY(1), .MAX_DLY(3), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .antecedent(a1), .consequent(c1), .fail(f1), .err_sticky(e1),
        .pass_cnt(pc1), .fail_cnt(fc1), .first_fail_vld(v1),
        .first_fail_ch(ch1), .first_fail_ts(ts1));

    impl_chk #(.NUM_CH(1), .MIN_DLY(0), .MAX_DLY(3), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .antecedent(a2), .consequent(c2), .fail(f2), .err_sticky(e2),
        .pass_cnt(pc2), .fail_cnt(fc2), .first_fail_vld(v2),
        .first_fail_ch(ch2), .first_fail_ts(ts2));

    impl_chk #(.NUM_CH(4), .MIN_DLY(0), .MAX_DLY(0), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .antecedent(a3), .consequent(c3), .fail(f3), .err_sticky(e3),
        .pass_cnt(pc3), .fail_cnt(fc3), .first_fail_vld(v3),
        .first_fail_ch(ch3), .first_fail_ts(ts3));

    impl_chk #(.NUM_CH(1), .MIN_DLY(0), .MAX_DLY(0), .CNT_W(2)) u4 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .antecedent(a4), .consequent(c4), .fail(f4), .err_sticky(e4),
        .pass_cnt(pc4), .fail_cnt(fc4), .first_fail_vld(v4),
        .first_fail_ch(ch4), .first_fail_ts(ts4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if ({f0, e0, v0, ch0} !== 4'b0) begin failures++; $display("FAIL reset_u0_bits got=%b exp=0000", {f0, e0, v0, ch0}); end
        checks++; if ({pc0, fc0} !== 32'd0) begin failures++; $display("FAIL reset_u0_cnt got=%h exp=0", {pc0, fc0}); end
        checks++; if (ts0 !== 32'd0) begin failures++; $display("FAIL reset_u0_ts got=%0d exp=0", ts0); end
        checks++; if ({f3, e3, v3, ch3} !== 11'd0) begin failures++; $display("FAIL reset_u3 got=%b exp=0", {f3, e3, v3, ch3}); end
        checks++; if ({fc4, pc4, f1, fc1} !== 20'd0) begin failures++; $display("FAIL reset_misc got=%h exp=0", {fc4, pc4, f1, fc1}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        a0 = 1'b1; c0 = 1'b1;
        tick();
        a0 = 1'b0; c0 = 1'b0;
        checks++; if (f0 !== 1'b0) begin failures++; $display("FAIL basic_pass_fail got=%b exp=0", f0); end
        checks++; if (pc0 !== 16'd1) begin failures++; $display("FAIL basic_pass_cnt got=%0d exp=1", pc0); end
        a0 = 1'b1;
        tick();
        a0 = 1'b0;
        checks++; if (f0 !== 1'b1) begin failures++; $display("FAIL basic_fail_pulse got=%b exp=1", f0); end
        checks++; if (e0 !== 1'b1) begin failures++; $display("FAIL basic_sticky got=%b exp=1", e0); end
        checks++; if (fc0 !== 16'd1) begin failures++; $display("FAIL basic_fail_cnt got=%0d exp=1", fc0); end
        tick();
        checks++; if ({f0, e0} !== 2'b01) begin failures++; $display("FAIL basic_one_cycle got=%b exp=01", {f0, e0}); end
        c0 = 1'b1;
        tick();
        c0 = 1'b0;
        checks++; if ({f0, pc0, fc0} !== {1'b0, 16'd1, 16'd1}) begin failures++; $display("FAIL basic_con_alone f=%b pc=%0d fc=%0d exp 0/1/1", f0, pc0, fc0); end
    endtask

    task automatic test_window();
        logic seen;
        a1 = 1'b1; c1 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            a1 = 1'b0; c1 = 1'b0;
            checks++; if (f1 !== (k == 4)) begin failures++; $display("FAIL window_early_con k=%0d got=%b exp=%b", k, f1, (k == 4)); end
        end
        tick();
        checks++; if ({f1, pc1, fc1} !== {1'b0, 16'd0, 16'd1}) begin failures++; $display("FAIL window_counts f=%b pc=%0d fc=%0d exp 0/0/1", f1, pc1, fc1); end
        a1 = 1'b1;
        tick();
        a1 = 1'b0; c1 = 1'b1;
        tick();
        c1 = 1'b0;
        checks++; if (pc1 !== 16'd1) begin failures++; $display("FAIL window_min_pass got=%0d exp=1", pc1); end
        a1 = 1'b1;
        tick();
        a1 = 1'b0;
        tick();
        tick();
        c1 = 1'b1;
        tick();
        c1 = 1'b0;
        checks++; if (pc1 !== 16'd2) begin failures++; $display("FAIL window_max_pass got=%0d exp=2", pc1); end
        seen = f1;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen = seen | f1;
        end
        checks++; if ({seen, fc1} !== {1'b0, 16'd1}) begin failures++; $display("FAIL window_no_fail seen=%b fc=%0d exp 0/1", seen, fc1); end
    endtask

    task automatic test_overlap();
        logic seen;
        a2 = 1'b1;
        tick();
        tick();
        tick();
        a2 = 1'b0; c2 = 1'b1;
        tick();
        c2 = 1'b0;
        checks++; if (pc2 !== 16'd3) begin failures++; $display("FAIL overlap_pass_cnt got=%0d exp=3", pc2); end
        seen = f2;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen = seen | f2;
        end
        checks++; if ({seen, fc2} !== {1'b0, 16'd0}) begin failures++; $display("FAIL overlap_no_fail seen=%b fc=%0d exp 0/0", seen, fc2); end
    endtask

    task automatic test_multi_ch();
        int exp_ts;
        exp_ts = tb_cyc;
        a3 = 4'b1010;
        tick();
        a3 = 4'b0000;
        checks++; if (f3 !== 4'b1010) begin failures++; $display("FAIL mch_fail got=%b exp=1010", f3); end
        checks++; if (fc3 !== 16'd2) begin failures++; $display("FAIL mch_fail_cnt got=%0d exp=2", fc3); end
        checks++; if (e3 !== 4'b1010) begin failures++; $display("FAIL mch_sticky got=%b exp=1010", e3); end
`ifdef IMPL_CHK_TIMESTAMP_EN
        checks++; if ({v3, ch3} !== 3'b101) begin failures++; $display("FAIL mch_first got=%b exp=101", {v3, ch3}); end
        checks++; if (ts3 !== 32'(exp_ts)) begin failures++; $display("FAIL mch_first_ts got=%0d exp=%0d", ts3, exp_ts); end
`else
        checks++; if ({v3, ch3, ts3} !== 35'd0) begin failures++; $display("FAIL mch_first_off got=%h exp=0", {v3, ch3, ts3}); end
`endif
        a3 = 4'b0111; c3 = 4'b0010;
        tick();
        a3 = 4'b0000; c3 = 4'b0000;
        checks++; if ({f3, e3} !== 8'b0101_1111) begin failures++; $display("FAIL mch_second got=%b exp=01011111", {f3, e3}); end
        checks++; if ({pc3, fc3} !== {16'd1, 16'd4}) begin failures++; $display("FAIL mch_second_cnt pc=%0d fc=%0d exp 1/4", pc3, fc3); end
`ifdef IMPL_CHK_TIMESTAMP_EN
        checks++; if ({v3, ch3, ts3} !== {1'b1, 2'd1, 32'(exp_ts)}) begin failures++; $display("FAIL mch_first_hold got=%h exp=%h", {v3, ch3, ts3}, {1'b1, 2'd1, 32'(exp_ts)}); end
`endif
        tick();
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 5; k++) begin
            a4 = 1'b1;
            tick();
            a4 = 1'b0;
            tick();
        end
        checks++; if ({fc4, e4} !== 3'b111) begin failures++; $display("FAIL sat_hold fc=%0d e=%b exp 3/1", fc4, e4); end
        a4 = 1'b1; clear = 1'b1;
        tick();
        a4 = 1'b0; clear = 1'b0;
        checks++; if ({f4, fc4, e4} !== 4'b1000) begin failures++; $display("FAIL sat_clear_wins f=%b fc=%0d e=%b exp 1/0/0", f4, fc4, e4); end
        checks++; if ({e3, pc3, fc3, v3} !== 37'd0) begin failures++; $display("FAIL clear_other got=%h exp=0", {e3, pc3, fc3, v3}); end
        tick();
    endtask

    task automatic test_reset_drop();
        logic seen;
        a1 = 1'b1;
        tick();
        a1 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen = seen | f1;
        end
        checks++; if ({seen, fc1, e1} !== 18'd0) begin failures++; $display("FAIL rst_drop seen=%b fc=%0d e=%b exp 0/0/0", seen, fc1, e1); end
        enable = 1'b0; a1 = 1'b1; a0 = 1'b1;
        tick();
        a1 = 1'b0; a0 = 1'b0;
        checks++; if (f0 !== 1'b0) begin failures++; $display("FAIL en_mask_u0 got=%b exp=0", f0); end
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen = seen | f1 | f0;
        end
        enable = 1'b1;
        checks++; if ({seen, fc0, fc1, e0} !== 34'd0) begin failures++; $display("FAIL en_mask seen=%b fc0=%0d fc1=%0d e0=%b exp 0", seen, fc0, fc1, e0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window();
        test_overlap();
        test_multi_ch();
        test_saturate();
        test_reset_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
